// File: rtl/pulse_meter.sv
// pulse_meter: measures the high width and rise-to-rise period of an asynchronous pulse train.
// Optional build macro PULSE_METER_GLITCH_FILTER_EN adds a 2-cycle agreement filter after the synchroniser.
module pulse_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_sat,
  output logic [CNT_W-1:0] pulse_count,
  output logic             overrun,
  output logic             busy
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync2_q, level_q;
  logic             rise, fall;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, pcnt_q;
  logic             load_cnt, inc_w, inc_p, publish, pub_sat;
  logic             take;
  logic             meas_valid_q, meas_sat_q, overrun_q;
  logic [CNT_W-1:0] high_cnt_q, period_cnt_q, pulse_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PULSE_METER_GLITCH_FILTER_EN
  // The strobe fires on the second consecutive cycle of disagreement, so it is one cycle later than unfiltered.
  logic diff_q;
  logic accept;

  assign accept = diff_q && (sync2_q != level_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      diff_q  <= 1'b0;
    end else begin
      diff_q <= (sync2_q != level_q) && !accept;
      if (accept) level_q <= sync2_q;
    end
  end

  assign rise = accept & sync2_q;
  assign fall = accept & ~sync2_q;
`else
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= sync2_q;
  end

  assign rise = sync2_q & ~level_q;
  assign fall = ~sync2_q & level_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM:  if (rise) state_d = S_HIGH;
        S_HIGH: begin
          if (pcnt_q == CNT_MAX) state_d = S_ARM;
          else if (fall)         state_d = S_LOW;
        end
        S_LOW: begin
          if (rise)                   state_d = S_HIGH;
          else if (pcnt_q == CNT_MAX) state_d = S_ARM;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The period counter always leads the width counter, so it alone decides saturation.
  always_comb begin
    load_cnt = 1'b0;
    inc_w    = 1'b0;
    inc_p    = 1'b0;
    publish  = 1'b0;
    pub_sat  = 1'b0;
    busy     = (state_q != S_IDLE);
    if (enable) begin
      case (state_q)
        S_ARM: load_cnt = rise;
        S_HIGH: begin
          if (pcnt_q == CNT_MAX) begin
            publish = 1'b1;
            pub_sat = 1'b1;
          end else begin
            inc_p = 1'b1;
            inc_w = !fall;
          end
        end
        S_LOW: begin
          if (rise) begin
            publish  = 1'b1;
            load_cnt = 1'b1;
          end else if (pcnt_q == CNT_MAX) begin
            publish = 1'b1;
            pub_sat = 1'b1;
          end else begin
            inc_p = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      pcnt_q <= '0;
    end else if (load_cnt) begin
      wcnt_q <= CNT_ONE;
      pcnt_q <= CNT_ONE;
    end else begin
      if (inc_w) wcnt_q <= wcnt_q + CNT_ONE;
      if (inc_p) pcnt_q <= pcnt_q + CNT_ONE;
    end
  end

  assign take = publish && (!meas_valid_q || meas_ready);

  // A result arriving while the previous one is still unconsumed is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_valid_q  <= 1'b0;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      meas_sat_q    <= 1'b0;
      pulse_count_q <= '0;
      overrun_q     <= 1'b0;
    end else if (take) begin
      meas_valid_q  <= 1'b1;
      high_cnt_q    <= wcnt_q;
      period_cnt_q  <= pcnt_q;
      meas_sat_q    <= pub_sat;
      pulse_count_q <= pulse_count_q + CNT_ONE;
    end else begin
      if (publish)                   overrun_q    <= 1'b1;
      if (meas_valid_q && meas_ready) meas_valid_q <= 1'b0;
    end
  end

  assign meas_valid  = meas_valid_q;
  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign meas_sat    = meas_sat_q;
  assign pulse_count = pulse_count_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed checks of pulse_meter (4-bit counters) with hand-computed results.
module tb_pulse_meter;
  localparam int TW = 4;
`ifdef PULSE_METER_GLITCH_FILTER_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          pulse_in = 1'b0;
  logic          meas_ready = 1'b0;
  logic          meas_valid, meas_sat, overrun, busy;
  logic [TW-1:0] high_cnt, period_cnt, pulse_count;
  int            n_cmp = 0;
  int            n_err = 0;

  pulse_meter #(.CNT_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pulse_in   (pulse_in),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_sat   (meas_sat),
    .pulse_count(pulse_count),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag, input int h, input int p, input int s, input int c);
    $display("result %s: high=%0d period=%0d sat=%0d count=%0d", tag, high_cnt, period_cnt, meas_sat, pulse_count);
    check_value({tag, ".high"}, high_cnt, h);
    check_value({tag, ".period"}, period_cnt, p);
    check_value({tag, ".sat"}, meas_sat, s);
    check_value({tag, ".count"}, pulse_count, c);
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, ".valid"}, meas_valid, 0);
    check_value({tag, ".high"}, high_cnt, 0);
    check_value({tag, ".period"}, period_cnt, 0);
    check_value({tag, ".sat"}, meas_sat, 0);
    check_value({tag, ".count"}, pulse_count, 0);
    check_value({tag, ".overrun"}, overrun, 0);
    check_value({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    // Reset values.
    repeat (2) tick();
    check_reset_state("rst");

    // Steady train H=5, L=3 with the consumer always ready.
    reset = 1'b0; enable = 1'b1; meas_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 42; i++) begin
      pulse_in = ((i % 8) < 5);
      tick();
      check_value("h5l3.valid", meas_valid, (i >= 10 + D) && ((i - 10 - D) % 8 == 0));
      if (meas_valid) check_result("h5l3", 5, 8, 0, (i - 10 - D) / 8 + 1);
    end

    // Consumer stalled across two H=2, L=2 periods: first result held, second dropped.
    pulse_in = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; meas_ready = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 12; i++) begin
      pulse_in = ((i % 4) < 2);
      tick();
      check_value("stall.valid", meas_valid, i >= 6 + D);
      check_value("stall.overrun", overrun, i >= 10 + D);
    end
    check_result("stall", 2, 4, 0, 1);
    meas_ready = 1'b1; pulse_in = 1'b0;
    tick();
    check_value("consume.valid", meas_valid, 0);
    check_value("consume.count", pulse_count, 1);
    check_value("consume.overrun", overrun, 1);
    check_value("consume.high", high_cnt, 2);
    repeat (2) tick();

    // Enable dropped while in LOW: no result, idle on the next cycle.
    enable = 1'b0;
    tick();
    check_value("disable.busy", busy, 0);
    check_value("disable.valid", meas_valid, 0);
    check_value("disable.count", pulse_count, 1);
    repeat (2) tick();

    // Re-enable mid-high skips the partial pulse; later a reset lands mid-HIGH with a held result.
    for (int i = 0; i < 28; i++) begin
      pulse_in   = (i < 6) ? 1'b1 : (i < 9) ? 1'b0 : (((i - 9) % 7) < 4);
      enable     = (i >= 3);
      meas_ready = (i <= 19 + D);
      reset      = (i == 27);
      tick();
      if (i < 27) begin
        check_value("reen.valid", meas_valid, (i == 18 + D) || (i >= 25 + D));
        check_value("reen.busy", busy, i >= 3);
        if (i == 18 + D) check_result("reen1", 4, 7, 0, 2);
        if (i == 25 + D) check_result("reen2", 4, 7, 0, 3);
      end else begin
        check_reset_state("midrst");
      end
    end

    // Saturation: pulse held high 20 cycles, then a clean H=2, L=2 measurement.
    reset = 1'b0; enable = 1'b1; meas_ready = 1'b1; pulse_in = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 30 + D; i++) begin
      pulse_in = (i < 20) ? 1'b1 : (i < 23) ? 1'b0 : (((i - 23) % 4) < 2);
      tick();
      check_value("sat.valid", meas_valid, (i == 17 + D) || (i == 29 + D));
      if (i == 17 + D) check_result("sat", 15, 15, 1, 1);
      if (i == 29 + D) check_result("post_sat", 2, 4, 0, 2);
      if (i == 20) check_value("sat.busy", busy, 1);
    end

    // Single-cycle glitch inside a low phase.
    pulse_in = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 15; i++) begin
      pulse_in = (i < 3) || (i == 6) || ((i >= 10) && (i < 13));
      tick();
`ifdef PULSE_METER_GLITCH_FILTER_EN
      check_value("glitch.valid", meas_valid, i == 13);
      if (i == 13) check_result("glitch", 3, 10, 0, 1);
`else
      check_value("glitch.valid", meas_valid, (i == 8) || (i == 12));
      if (i == 8)  check_result("glitch1", 3, 6, 0, 1);
      if (i == 12) check_result("glitch2", 1, 4, 0, 2);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
